// File: rtl/transmission_estimator.sv
// ---------------------------------------------------------------------------
// transmission_estimator
//
// Purpose:
//   Converts the dark-channel pixel stream into a transmission map
//   t = 1 - OMEGA * dark / A (Q0.8), clamped below at T_MIN. The reciprocal
//   1/A is computed once per frame by a bit-serial restoring divider, so the
//   pixel path only needs multipliers.
//
// Ports:
//   clk, rst          pixel clock, synchronous active-high reset
//   dark              dark-channel pixel (8 bit)
//   hsync/vsync/en    sync and valid strobes aligned with dark
//   max_of_dark       frame maximum, candidate atmospheric light A
//   frame_done_flag   single-cycle end-of-frame pulse; captures A
//   t                 transmission, Q0.8, valid 3 cycles after dark
//   o_hsync/o_vsync/o_en  sync strobes delayed 3 cycles to align with t
//   a_value           atmospheric light currently used by the pixel path
//   recip_busy        high while the divider runs (DIV and LOAD)
//   o_fsm_state       debug view of the divider FSM (0 IDLE, 1 DIV, 2 LOAD)
//   o_recip           debug view of the reciprocal in use (65536 / A)
//
// Handshake: there is no backpressure. The pixel path accepts one sample
// per clock unconditionally; en is only carried along, never gates logic.
// ---------------------------------------------------------------------------
module transmission_estimator #(
   parameter logic [7:0] OMEGA = 8'd243,
   parameter logic [7:0] T_MIN = 8'd26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  dark,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        en,
   input  logic [7:0]  max_of_dark,
   input  logic        frame_done_flag,
   output logic [7:0]  t,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_en,
   output logic [7:0]  a_value,
   output logic        recip_busy,
   output logic [1:0]  o_fsm_state,
   output logic [16:0] o_recip
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_a_next;
   logic [16:0] r_quot;
   logic [7:0]  r_rem;
   logic [4:0]  r_bit;
   logic [16:0] r_recip;
   logic [7:0]  r_a_value;

   // ---------------- reciprocal divider ----------------
   // Dividend is 65536: only bit 16 is set, so the next dividend bit is
   // simply "are we on the first step".
   logic [8:0] w_rem_shift;
   logic       w_rem_ge;
   logic [7:0] w_rem_next;

   always_comb begin
      w_rem_shift = {r_rem, (r_bit == 5'd16)};
      w_rem_ge    = (w_rem_shift >= {1'b0, r_a_next});
      w_rem_next  = w_rem_ge ? 8'(w_rem_shift - {1'b0, r_a_next})
                             : w_rem_shift[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_a_next  <= 8'd255;
         r_quot    <= '0;
         r_rem     <= '0;
         r_bit     <= '0;
         r_recip   <= 17'd257;
         r_a_value <= 8'd255;
      end else if (frame_done_flag) begin
         // A new frame end always restarts the division, aborting any
         // run in progress; the old recip/a_value stay in use meanwhile.
         r_a_next <= (max_of_dark == 8'd0) ? 8'd1 : max_of_dark;
         r_quot   <= '0;
         r_rem    <= '0;
         r_bit    <= 5'd16;
         r_state  <= S_DIV;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            S_DIV: begin
               r_rem  <= w_rem_next;
               r_quot <= {r_quot[15:0], w_rem_ge};
               if (r_bit == 5'd0) begin
                  r_state <= S_LOAD;
               end else begin
                  r_bit <= r_bit - 5'd1;
               end
            end
            S_LOAD: begin
               r_recip   <= r_quot;
               r_a_value <= r_a_next;
               r_state   <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign recip_busy  = (r_state != S_IDLE);
   assign a_value     = r_a_value;
   assign o_fsm_state = r_state;
   assign o_recip     = r_recip;

   // ---------------- pixel pipeline ----------------
   logic [15:0] r_p1;
   logic [7:0]  r_ratio;
   logic [2:0]  r_sync_d1;
   logic [2:0]  r_sync_d2;
   logic [15:0] w_p1;
   logic [32:0] w_prod;
   logic [16:0] w_ratio;
   logic [7:0]  w_ratio_sat;
   logic [7:0]  w_inv;

   always_comb begin
      w_p1        = 16'(dark) * 16'(OMEGA);
      // recip can be 65536 (A=1), so the product needs the full 33 bits.
      w_prod      = 33'(r_p1) * 33'(r_recip);
      w_ratio     = 17'(w_prod >> 16);
      w_ratio_sat = (|w_ratio[16:8]) ? 8'hFF : w_ratio[7:0];
      w_inv       = 8'd255 - r_ratio;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p1      <= '0;
         r_ratio   <= '0;
         t         <= '0;
         r_sync_d1 <= '0;
         r_sync_d2 <= '0;
         o_hsync   <= 1'b0;
         o_vsync   <= 1'b0;
         o_en      <= 1'b0;
      end else begin
         r_p1      <= w_p1;
         r_ratio   <= w_ratio_sat;
         t         <= (w_inv < T_MIN) ? T_MIN : w_inv;
         r_sync_d1 <= {hsync, vsync, en};
         r_sync_d2 <= r_sync_d1;
         o_hsync   <= r_sync_d2[2];
         o_vsync   <= r_sync_d2[1];
         o_en      <= r_sync_d2[0];
      end
   end

endmodule

// File: tb/tb_transmission_estimator.sv
// ---------------------------------------------------------------------------
// tb_transmission_estimator
//
// Purpose: self-checking bench for transmission_estimator. A reference model
// computes t directly from the defining formula using the reciprocal 65536/A
// and integer arithmetic; sync outputs are expected to equal the inputs
// three cycles earlier.
// ---------------------------------------------------------------------------
module tb_transmission_estimator;

   logic        clk;
   logic        rst;
   logic [7:0]  dark;
   logic        hsync;
   logic        vsync;
   logic        en;
   logic [7:0]  max_of_dark;
   logic        frame_done_flag;
   logic [7:0]  t;
   logic        o_hsync;
   logic        o_vsync;
   logic        o_en;
   logic [7:0]  a_value;
   logic        recip_busy;
   logic [1:0]  o_fsm_state;
   logic [16:0] o_recip;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: atmospheric light and reciprocal in use
   int m_a     = 255;
   int m_recip = 257;

   logic [10:0] exp_q[$];

   transmission_estimator dut (
      .clk             (clk),
      .rst             (rst),
      .dark            (dark),
      .hsync           (hsync),
      .vsync           (vsync),
      .en              (en),
      .max_of_dark     (max_of_dark),
      .frame_done_flag (frame_done_flag),
      .t               (t),
      .o_hsync         (o_hsync),
      .o_vsync         (o_vsync),
      .o_en            (o_en),
      .a_value         (a_value),
      .recip_busy      (recip_busy),
      .o_fsm_state     (o_fsm_state),
      .o_recip         (o_recip)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- model ----------------
   function automatic logic [7:0] model_t(input int d, input int recip);
      longint ratio;
      int     tv;
      ratio = (longint'(d) * 243 * longint'(recip)) / 65536;
      if (ratio > 255) ratio = 255;
      tv = 255 - int'(ratio);
      if (tv < 26) tv = 26;
      return 8'(tv);
   endfunction

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_model_a(input int a_in);
      m_a     = (a_in == 0) ? 1 : a_in;
      m_recip = 65536 / m_a;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      dark = 8'($urandom_range(0, 255));
      hsync = 1'b1; vsync = 1'b1; en = 1'b1;
      max_of_dark = 8'd77;
      frame_done_flag = 1'b1;
      step();
      step();
      n_cmp++;
      if ({t, o_hsync, o_vsync, o_en} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_outputs: got t=%0d h=%0b v=%0b en=%0b, want all 0", t, o_hsync, o_vsync, o_en);
      end
      n_cmp++;
      if (a_value !== 8'd255 || o_recip !== 17'd257) begin
         n_err++;
         $display("FAIL reset_a_recip: got a=%0d recip=%0d, want 255/257", a_value, o_recip);
      end
      n_cmp++;
      if (recip_busy !== 1'b0 || o_fsm_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_fsm: got busy=%0b state=%0d, want 0/0", recip_busy, o_fsm_state);
      end
      rst = 1'b0;
      frame_done_flag = 1'b0;
      set_model_a(255);
   endtask

   task automatic test_default_pixel();
      dark = 8'd0; en = 1'b1; hsync = 1'b0; vsync = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if (recip_busy !== 1'b0 || a_value !== 8'd255) begin
            n_err++;
            $display("FAIL default_idle: got busy=%0b a=%0d, want 0/255", recip_busy, a_value);
         end
      end
      n_cmp++;
      if (t !== 8'd255 || o_en !== 1'b1) begin
         n_err++;
         $display("FAIL default_pixel: got t=%0d en=%0b, want 255/1", t, o_en);
      end
   endtask

   task automatic test_random_stream(input int n);
      logic [10:0] got;
      logic [10:0] want;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         dark  = 8'($urandom_range(0, 255));
         hsync = 1'($urandom_range(0, 1));
         vsync = 1'($urandom_range(0, 1));
         en    = 1'($urandom_range(0, 1));
         exp_q.push_back({model_t(int'(dark), m_recip), hsync, vsync, en});
         step();
         if (i >= 2) begin
            got  = {t, o_hsync, o_vsync, o_en};
            want = exp_q.pop_front();
            n_cmp++;
            if (got !== want) begin
               n_err++;
               $display("FAIL stream[%0d] A=%0d: got t=%0d hve=%03b, want t=%0d hve=%03b",
                        i, m_a, got[10:3], got[2:0], want[10:3], want[2:0]);
            end
         end
      end
   endtask

   task automatic test_division(input int a_in);
      int cnt;
      max_of_dark = 8'(a_in);
      frame_done_flag = 1'b1;
      step();
      frame_done_flag = 1'b0;
      max_of_dark = 8'($urandom_range(0, 255));
      cnt = 0;
      while (recip_busy === 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
      set_model_a(a_in);
      n_cmp++;
      if (cnt !== 18) begin
         n_err++;
         $display("FAIL div_busy_len A=%0d: got %0d cycles, want 18", a_in, cnt);
      end
      n_cmp++;
      if (int'(a_value) !== m_a || int'(o_recip) !== m_recip) begin
         n_err++;
         $display("FAIL div_result A=%0d: got a=%0d recip=%0d, want a=%0d recip=%0d",
                  a_in, a_value, o_recip, m_a, m_recip);
      end
   endtask

   task automatic test_directed_t();
      int d_tab[4];
      d_tab = '{0, 100, 200, 255};
      for (int k = 0; k < 4; k++) begin
         dark = 8'(d_tab[k]); en = 1'b1;
         step(); step(); step();
         n_cmp++;
         if (t !== model_t(d_tab[k], m_recip)) begin
            n_err++;
            $display("FAIL directed_t A=%0d dark=%0d: got t=%0d, want %0d",
                     m_a, d_tab[k], t, model_t(d_tab[k], m_recip));
         end
      end
   endtask

   task automatic test_a200_points();
      int d_tab[3];
      int t_tab[3];
      d_tab = '{100, 200, 255};
      t_tab = '{134, 26, 26};
      for (int k = 0; k < 3; k++) begin
         dark = 8'(d_tab[k]);
         step(); step(); step();
         n_cmp++;
         if (int'(t) !== t_tab[k]) begin
            n_err++;
            $display("FAIL a200_t dark=%0d: got t=%0d, want %0d", d_tab[k], t, t_tab[k]);
         end
      end
   endtask

   task automatic test_abort();
      int old_a;
      int old_recip;
      int cnt;
      old_a = m_a;
      old_recip = m_recip;
      max_of_dark = 8'd100;
      frame_done_flag = 1'b1;
      step();
      frame_done_flag = 1'b0;
      for (int k = 1; k < 5; k++) begin
         step();
         n_cmp++;
         if (int'(a_value) !== old_a || int'(o_recip) !== old_recip || recip_busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_hold: got a=%0d recip=%0d busy=%0b, want a=%0d recip=%0d busy=1",
                     a_value, o_recip, recip_busy, old_a, old_recip);
         end
      end
      max_of_dark = 8'd50;
      frame_done_flag = 1'b1;
      step();
      frame_done_flag = 1'b0;
      cnt = 0;
      while (recip_busy === 1'b1 && cnt < 100) begin
         cnt++;
         step();
      end
      set_model_a(50);
      n_cmp++;
      if (cnt !== 18) begin
         n_err++;
         $display("FAIL abort_busy_len: got %0d cycles, want 18", cnt);
      end
      n_cmp++;
      if (a_value !== 8'd50 || o_recip !== 17'd1310) begin
         n_err++;
         $display("FAIL abort_result: got a=%0d recip=%0d, want 50/1310", a_value, o_recip);
      end
   endtask

   task automatic test_reset_mid_div();
      max_of_dark = 8'd123;
      frame_done_flag = 1'b1;
      dark = 8'd9; hsync = 1'b1; vsync = 1'b1; en = 1'b1;
      step();
      frame_done_flag = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_model_a(255);
      n_cmp++;
      if (recip_busy !== 1'b0 || a_value !== 8'd255 || o_recip !== 17'd257) begin
         n_err++;
         $display("FAIL rst_mid_div_fsm: got busy=%0b a=%0d recip=%0d, want 0/255/257",
                  recip_busy, a_value, o_recip);
      end
      n_cmp++;
      if ({t, o_hsync, o_vsync, o_en} !== 11'd0) begin
         n_err++;
         $display("FAIL rst_mid_div_out: got t=%0d h=%0b v=%0b en=%0b, want all 0",
                  t, o_hsync, o_vsync, o_en);
      end
      // divider must stay idle after the aborted run
      step(); step();
      n_cmp++;
      if (recip_busy !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_div_idle: got busy=%0b, want 0", recip_busy);
      end
   endtask

   // ---------------- sequence ----------------
   initial begin
      rst = 1'b1;
      dark = '0; hsync = 1'b0; vsync = 1'b0; en = 1'b0;
      max_of_dark = '0; frame_done_flag = 1'b0;

      test_reset();
      test_default_pixel();
      test_random_stream(40);
      test_division(200);
      test_a200_points();
      test_random_stream(60);
      test_division(0);
      test_directed_t();
      test_random_stream(40);
      test_abort();
      test_random_stream(40);
      test_division(int'($urandom_range(2, 255)));
      test_directed_t();
      test_random_stream(40);
      test_reset_mid_div();
      test_random_stream(60);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
